// File: rtl/pfq_if.sv
// Bus bundle for prefetch_queue: producer push handshake, consumer pop/flush and output window.
interface pfq_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIN   = 4
);
    localparam int unsigned PCW = $clog2(WIN + 1);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    logic              push_valid;
    logic [W-1:0]      push_data;
    logic              push_ready;
    logic [PCW-1:0]    pop_cnt;
    logic              flush;
    logic [W*WIN-1:0]  win_data;
    logic [WIN-1:0]    win_valid;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;

    modport master (
        output push_valid, push_data, pop_cnt, flush,
        input  push_ready, win_data, win_valid, count, empty, full
    );

    modport slave (
        input  push_valid, push_data, pop_cnt, flush,
        output push_ready, win_data, win_valid, count, empty, full
    );
endinterface

// File: rtl/prefetch_queue.sv
// Circular prefetch queue: single push per cycle, multi-entry pop, WIN oldest entries exposed.
// Optional flush support enabled by defining PFQ_FLUSH_EN.
module prefetch_queue #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIN   = 4
) (
    input  logic clk,
    input  logic rst,
    pfq_if.slave q
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_push;
    logic [CW-1:0] w_pop_req;
    logic [CW-1:0] w_pop;
    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;

    // Pointer advance modulo DEPTH; increment never exceeds DEPTH, so one subtract suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [SW-1:0] inc);
        logic [SW-1:0] s;
        s = SW'(ptr) + inc;
        if (s >= SW'(DEPTH)) s = s - SW'(DEPTH);
        return PW'(s);
    endfunction

    assign w_full = (r_count == CW'(DEPTH));

`ifdef PFQ_FLUSH_EN
    assign w_push = q.push_valid && !w_full && !q.flush;
`else
    assign w_push = q.push_valid && !w_full;
`endif

    // Over-requested pops are clamped to the current occupancy.
    assign w_pop_req  = CW'(q.pop_cnt);
    assign w_pop      = (w_pop_req > r_count) ? r_count : w_pop_req;
    assign w_head_nxt = wrap_add(r_head, SW'(w_pop));
    assign w_tail_nxt = wrap_add(r_tail, SW'(w_push));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
`ifdef PFQ_FLUSH_EN
            if (q.flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= w_head_nxt;
                r_tail  <= w_tail_nxt;
                r_count <= r_count + CW'(w_push) - w_pop;
            end
`else
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= r_count + CW'(w_push) - w_pop;
`endif
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= q.push_data;
    end

    always_comb begin
        q.win_data  = '0;
        q.win_valid = '0;
        for (int unsigned i = 0; i < WIN; i++) begin
            if (CW'(i) < r_count) begin
                q.win_valid[WIN-1-i]           = 1'b1;
                q.win_data[W*(WIN-i)-1 -: W]   = r_mem[wrap_add(r_head, SW'(i))];
            end
        end
    end

    assign q.count      = r_count;
    assign q.empty      = (r_count == '0);
    assign q.full       = w_full;
    assign q.push_ready = !w_full;
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: DEPTH=8 and DEPTH=6 instances against a queue-based reference model.
module tb_prefetch_queue;
`ifdef PFQ_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pfq_if #(.W(8), .DEPTH(8), .WIN(4)) if8 ();
    pfq_if #(.W(8), .DEPTH(6), .WIN(4)) if6 ();

    prefetch_queue #(.W(8), .DEPTH(8), .WIN(4)) u_pfq8 (.clk(clk), .rst(rst), .q(if8));
    prefetch_queue #(.W(8), .DEPTH(6), .WIN(4)) u_pfq6 (.clk(clk), .rst(rst), .q(if6));

    int checks = 0;
    int errors = 0;
    logic [7:0] m8[$];
    logic [7:0] m6[$];

    function automatic logic [31:0] exp_data(input bit six);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (six) begin
                if (i < m6.size()) r[31-8*i -: 8] = m6[i];
            end else if (i < m8.size()) begin
                r[31-8*i -: 8] = m8[i];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_valid(input bit six);
        logic [3:0] r;
        int n;
        r = '0;
        n = six ? m6.size() : m8.size();
        for (int i = 0; i < 4; i++) if (i < n) r[3-i] = 1'b1;
        return r;
    endfunction

    task automatic model_upd(input bit six, input logic pv, input logic [7:0] pd,
                             input logic [2:0] pc, input logic fl);
        int n, depth, np;
        bit psh;
        n     = six ? m6.size() : m8.size();
        depth = six ? 6 : 8;
        psh   = pv && (n < depth);
        np    = (int'(pc) > n) ? n : int'(pc);
        if (fl && FLUSH_ON) begin
            if (six) m6.delete(); else m8.delete();
        end else begin
            repeat (np) begin
                if (six) void'(m6.pop_front()); else void'(m8.pop_front());
            end
            if (psh) begin
                if (six) m6.push_back(pd); else m8.push_back(pd);
            end
        end
    endtask

    task automatic idle();
        if8.push_valid = 1'b0; if8.push_data = '0; if8.pop_cnt = '0; if8.flush = 1'b0;
        if6.push_valid = 1'b0; if6.push_data = '0; if6.pop_cnt = '0; if6.flush = 1'b0;
    endtask

    task automatic tick();
        logic pv8, pv6, fl8, fl6;
        logic [7:0] pd8, pd6;
        logic [2:0] pc8, pc6;
        pv8 = if8.push_valid; pd8 = if8.push_data; pc8 = if8.pop_cnt; fl8 = if8.flush;
        pv6 = if6.push_valid; pd6 = if6.push_data; pc6 = if6.pop_cnt; fl6 = if6.flush;
        @(posedge clk);
        if (rst) begin
            model_upd(1'b0, pv8, pd8, pc8, fl8);
            model_upd(1'b1, pv6, pd6, pc6, fl6);
        end
        #1;
    endtask

    task automatic push8(input logic [7:0] d);
        if8.push_valid = 1'b1; if8.push_data = d; tick(); if8.push_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        checks++; if (if8.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if8.count); end
        checks++; if (if8.empty !== 1'b1 || if8.full !== 1'b0 || if8.push_ready !== 1'b1) begin errors++; $display("FAIL reset_flags got e=%b f=%b r=%b exp 1 0 1", if8.empty, if8.full, if8.push_ready); end
        checks++; if (if8.win_valid !== 4'b0 || if8.win_data !== 32'h0) begin errors++; $display("FAIL reset_window got %b %h exp 0 0", if8.win_valid, if8.win_data); end
        checks++; if (if6.count !== 3'd0 || if6.empty !== 1'b1) begin errors++; $display("FAIL reset6 got %0d %b exp 0 1", if6.count, if6.empty); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_push_window();
        push8(8'h11);
        checks++; if (if8.count !== 4'd1 || if8.win_data !== 32'h11000000) begin errors++; $display("FAIL first_push got %0d %h exp 1 11000000", if8.count, if8.win_data); end
        push8(8'h22);
        push8(8'h33);
        checks++; if (if8.win_data !== 32'h11223300) begin errors++; $display("FAIL win3_data got %h exp 11223300", if8.win_data); end
        checks++; if (if8.win_valid !== 4'b1110) begin errors++; $display("FAIL win3_valid got %b exp 1110", if8.win_valid); end
        checks++; if (if8.count !== 4'd3) begin errors++; $display("FAIL win3_count got %0d exp 3", if8.count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) push8(8'($urandom));
        checks++; if (if8.full !== 1'b1 || if8.push_ready !== 1'b0 || if8.count !== 4'd8) begin errors++; $display("FAIL fill got f=%b r=%b c=%0d exp 1 0 8", if8.full, if8.push_ready, if8.count); end
        push8(8'hAA);
        checks++; if (if8.count !== 4'd8) begin errors++; $display("FAIL full_reject got %0d exp 8", if8.count); end
        checks++; if (if8.win_data !== exp_data(1'b0)) begin errors++; $display("FAIL full_window got %h exp %h", if8.win_data, exp_data(1'b0)); end
    endtask

    task automatic test_pop_push_full();
        if8.pop_cnt = 3'd3; if8.push_valid = 1'b1; if8.push_data = 8'hBB;
        tick();
        checks++; if (if8.count !== 4'd5) begin errors++; $display("FAIL pop_full_count got %0d exp 5", if8.count); end
        checks++; if (if8.win_data !== exp_data(1'b0)) begin errors++; $display("FAIL pop_full_window got %h exp %h", if8.win_data, exp_data(1'b0)); end
        if8.pop_cnt = 3'd0; if8.push_data = 8'hCC;
        tick();
        idle();
        checks++; if (if8.count !== 4'd6 || if8.push_ready !== 1'b1) begin errors++; $display("FAIL push_after_pop got %0d %b exp 6 1", if8.count, if8.push_ready); end
    endtask

    task automatic test_over_pop();
        if8.pop_cnt = 3'd4; tick();
        checks++; if (if8.count !== 4'd2) begin errors++; $display("FAIL pop4_count got %0d exp 2", if8.count); end
        tick();
        idle();
        checks++; if (if8.count !== 4'd0 || if8.empty !== 1'b1) begin errors++; $display("FAIL overpop got %0d %b exp 0 1", if8.count, if8.empty); end
        checks++; if (if8.win_valid !== 4'b0 || if8.win_data !== 32'h0) begin errors++; $display("FAIL overpop_window got %b %h exp 0 0", if8.win_valid, if8.win_data); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push8(8'($urandom));
        if8.flush = 1'b1; if8.push_valid = 1'b1; if8.push_data = 8'hEE;
        tick();
        idle();
        checks++; if (int'(if8.count) !== (FLUSH_ON ? 0 : 6)) begin errors++; $display("FAIL flush_count got %0d exp %0d", if8.count, FLUSH_ON ? 0 : 6); end
        checks++; if (if8.win_data !== exp_data(1'b0) || if8.win_valid !== exp_valid(1'b0)) begin errors++; $display("FAIL flush_window got %h %b exp %h %b", if8.win_data, if8.win_valid, exp_data(1'b0), exp_valid(1'b0)); end
        if8.pop_cnt = 3'd4; tick(); tick(); idle();
        checks++; if (if8.count !== 4'd0) begin errors++; $display("FAIL flush_drain got %0d exp 0", if8.count); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            if6.push_valid = 1'b1; if6.push_data = 8'(i + 1);
            push8(8'(i + 7));
        end
        idle();
        rst = 1'b0;
        #2;
        checks++; if (if8.count !== 4'd0 || if8.win_valid !== 4'b0 || if8.win_data !== 32'h0) begin errors++; $display("FAIL midreset8 got %0d %b %h exp 0 0 0", if8.count, if8.win_valid, if8.win_data); end
        checks++; if (if6.count !== 3'd0 || if6.win_data !== 32'h0) begin errors++; $display("FAIL midreset6 got %0d %h exp 0 0", if6.count, if6.win_data); end
        m8.delete(); m6.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        push8(8'h5A);
        checks++; if (if8.win_data !== 32'h5A000000 || if8.count !== 4'd1) begin errors++; $display("FAIL post_reset_push got %h %0d exp 5a000000 1", if8.win_data, if8.count); end
        if8.pop_cnt = 3'd1; tick(); idle();
    endtask

    task automatic test_random_wrap();
        for (int i = 0; i < 300; i++) begin
            int ppush;
            int pmax;
            ppush = (i % 60 < 30) ? 85 : 45;
            pmax  = (i % 60 < 30) ? 1 : 4;
            if8.push_valid = ($urandom_range(0, 99) < ppush);
            if8.push_data  = 8'($urandom);
            if8.pop_cnt    = 3'($urandom_range(0, pmax));
            if6.push_valid = ($urandom_range(0, 99) < ppush);
            if6.push_data  = 8'($urandom);
            if6.pop_cnt    = 3'($urandom_range(0, pmax));
            tick();
            checks++; if (int'(if8.count) !== m8.size() || if8.empty !== (m8.size() == 0) || if8.full !== (m8.size() == 8) || if8.push_ready !== (m8.size() != 8)) begin errors++; $display("FAIL rnd8_state cyc %0d got c=%0d e=%b f=%b r=%b exp c=%0d", i, if8.count, if8.empty, if8.full, if8.push_ready, m8.size()); end
            checks++; if (if8.win_data !== exp_data(1'b0) || if8.win_valid !== exp_valid(1'b0)) begin errors++; $display("FAIL rnd8_window cyc %0d got %h %b exp %h %b", i, if8.win_data, if8.win_valid, exp_data(1'b0), exp_valid(1'b0)); end
            checks++; if (int'(if6.count) !== m6.size() || if6.empty !== (m6.size() == 0) || if6.full !== (m6.size() == 6) || if6.push_ready !== (m6.size() != 6)) begin errors++; $display("FAIL rnd6_state cyc %0d got c=%0d e=%b f=%b r=%b exp c=%0d", i, if6.count, if6.empty, if6.full, if6.push_ready, m6.size()); end
            checks++; if (if6.win_data !== exp_data(1'b1) || if6.win_valid !== exp_valid(1'b1)) begin errors++; $display("FAIL rnd6_window cyc %0d got %h %b exp %h %b", i, if6.win_data, if6.win_valid, exp_data(1'b1), exp_valid(1'b1)); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_push_window();
        test_full();
        test_pop_push_full();
        test_over_pop();
        test_flush();
        test_mid_reset();
        test_random_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning bits per queue entry (one instruction byte).
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of entries; legal range WIN..64, not required to be a power of two.
REQ-003 The module SHALL have parameter WIN, default 4, meaning the number of oldest entries presented on the output window.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port push_valid, input, 1 bit: the producer offers push_data this cycle.
REQ-007 The module SHALL have port push_data, input, W bits: the entry to enqueue.
REQ-008 The module SHALL have port push_ready, output, 1 bit: the queue accepts a push this cycle.
REQ-009 The module SHALL have port pop_cnt, input, $clog2(WIN+1) bits: the number of head entries the consumer removes this cycle (0..WIN).
REQ-010 The module SHALL have port flush, input, 1 bit: discard all contents (active only with PFQ_FLUSH_EN).
REQ-011 The module SHALL have port win_data, output, W*WIN bits: the oldest WIN entries, oldest in the most-significant W bits.
REQ-012 The module SHALL have port win_valid, output, WIN bits: per-slot valid, MSB = oldest slot.
REQ-013 The module SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The module SHALL have ports empty and full, outputs, 1 bit each: count==0 and count==DEPTH.

Function
REQ-015 Storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH, including non-power-of-two DEPTH.
REQ-016 push_ready SHALL equal !full, derived from registered count only; it SHALL NOT depend on same-cycle pop_cnt.
REQ-017 A push SHALL occur iff push_valid && push_ready at the clock edge; the entry is written at tail and the tail advances by one.
REQ-018 Entries popped SHALL be min(pop_cnt, count); the head advances by that amount; over-requested pops are clamped, not errors.
REQ-019 count_next SHALL be count + pushed - popped, with simultaneous push and pop legal in the same cycle.
REQ-020 Window slot i (i=0 oldest) SHALL be driven from entry head+i mod DEPTH onto win_data[W*(WIN-i)-1 -: W], with win_valid[WIN-1-i] = (i < count).
REQ-021 Slots with win_valid low SHALL drive zero on win_data.
REQ-022 win_data, win_valid, count, empty and full SHALL be combinational from registered state; a pushed entry SHALL become visible the cycle after acceptance (latency 1).
REQ-023 A popped entry SHALL leave the window the cycle after the pop, and the remaining entries SHALL shift toward the MSB slot.
REQ-024 FIFO order SHALL be preserved across any number of pointer wrap-arounds.

Reset
REQ-025 While rst is low, head, tail and count SHALL be 0 asynchronously; empty=1, full=0, push_ready=1, win_valid=0, win_data=0.
REQ-026 Reset asserted mid-operation SHALL discard all contents; the storage array itself does not require reset.
REQ-027 The first push SHALL be accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-028 With macro PFQ_FLUSH_EN defined, flush=1 SHALL set head, tail and count to 0 at the next edge, dropping any same-cycle push and ignoring pop_cnt.
REQ-029 Without PFQ_FLUSH_EN, the flush input SHALL be ignored and no flush logic SHALL be generated.

Verification
REQ-030 After reset, push 0x11,0x22,0x33 on consecutive cycles -> next cycle win_data=0x11223300, win_valid=4'b1110, count=3.
REQ-031 Fill to DEPTH=8 -> full=1, push_ready=0; push_valid with push_data=0xAA is not accepted and count stays 8.
REQ-032 With count=8, pop_cnt=3 and push_valid=1 in the same cycle -> push rejected, count=5; next cycle push accepted, count=6.
REQ-033 With count=2 and pop_cnt=4 -> count=0, empty=1, win_valid=0, win_data=0.
REQ-034 Run 20 cycles of a mixed push/pop stream with DEPTH=6 -> window order matches a reference FIFO model across wrap-around.
REQ-035 With PFQ_FLUSH_EN, count=5, flush=1 and push_valid=1 -> count=0 next cycle; without the macro, count=6.
